// File: rtl/muldiv_if.sv
// Handshake and HI/LO bundle between the control unit and muldiv_unit.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply/divide unit owning the HI/LO registers.
// Define MULDIV_DIV_EN to compile in the restoring divider; otherwise DIV/DIVU complete as a no-op.
module muldiv_unit (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        logic [31:0] r;
        if (sgn && v[31]) r = ~v + 32'd1;
        else              r = v;
        return r;
    endfunction

    logic [1:0]  state_r;
    logic [5:0]  cnt_r;
    logic [31:0] opnd_r;
    logic [63:0] acc_r;
    logic        neg_q_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;
`ifdef MULDIV_DIV_EN
    logic        is_div_r;
    logic        neg_r_r;
    logic [32:0] rem_sh_s;
    logic [32:0] diff_s;
`endif

    logic        signed_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        launch_s;
    logic        div_nop_s;
    logic [32:0] sum_s;
    logic [63:0] acc_nxt_s;
    logic [63:0] prod_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;

    // Operand conditioning for an accepted start.
    always_comb begin
        signed_s = ~bus.op[0];
        neg_a_s  = signed_s & bus.src_a[31];
        neg_b_s  = signed_s & bus.src_b[31];
        mag_a_s  = mag32(bus.src_a, signed_s);
        mag_b_s  = mag32(bus.src_b, signed_s);
`ifdef MULDIV_DIV_EN
        launch_s  = bus.start;
        div_nop_s = 1'b0;
`else
        launch_s  = bus.start & ~bus.op[1];
        div_nop_s = bus.start &  bus.op[1];
`endif
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        sum_s     = 33'd0;
        acc_nxt_s = acc_r;
`ifdef MULDIV_DIV_EN
        rem_sh_s  = {acc_r[63:32], acc_r[31]};
        diff_s    = rem_sh_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (diff_s[32]) acc_nxt_s = {rem_sh_s[31:0], acc_r[30:0], 1'b0};
            else            acc_nxt_s = {diff_s[31:0],   acc_r[30:0], 1'b1};
        end else begin
            sum_s     = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
            acc_nxt_s = {sum_s, acc_r[31:1]};
        end
`else
        sum_s     = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        acc_nxt_s = {sum_s, acc_r[31:1]};
`endif
    end

    // Sign correction applied in FIX; divide by zero leaves the raw dividend in HI.
    always_comb begin
        if (neg_q_r) prod_s = ~acc_r + 64'd1;
        else         prod_s = acc_r;
        fix_hi_s = prod_s[63:32];
        fix_lo_s = prod_s[31:0];
`ifdef MULDIV_DIV_EN
        if (is_div_r) begin
            if (neg_r_r) fix_hi_s = ~acc_r[63:32] + 32'd1;
            else         fix_hi_s = acc_r[63:32];
            if (opnd_r == 32'd0) fix_lo_s = 32'hFFFF_FFFF;
            else if (neg_q_r)    fix_lo_s = ~acc_r[31:0] + 32'd1;
            else                 fix_lo_s = acc_r[31:0];
        end else begin
            fix_hi_s = prod_s[63:32];
            fix_lo_s = prod_s[31:0];
        end
`endif
    end

    // Control FSM, datapath registers and architectural HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 6'd0;
            opnd_r   <= 32'd0;
            acc_r    <= 64'd0;
            neg_q_r  <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_r <= 1'b0;
            neg_r_r  <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 6'd0;
                    if (launch_s) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        neg_q_r <= neg_a_s ^ neg_b_s;
`ifdef MULDIV_DIV_EN
                        is_div_r <= bus.op[1];
                        neg_r_r  <= neg_a_s;
                        opnd_r   <= bus.op[1] ? mag_b_s : mag_a_s;
                        acc_r    <= {32'd0, bus.op[1] ? mag_a_s : mag_b_s};
`else
                        opnd_r   <= mag_a_s;
                        acc_r    <= {32'd0, mag_b_s};
`endif
                    end else if (div_nop_s) begin
                        done_r <= 1'b1;
                    end else begin
                        if (bus.hi_we) hi_r <= bus.src_a;
                        if (bus.lo_we) lo_r <= bus.src_a;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_nxt_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) state_r <= ST_FIX;
                end
                ST_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit; covers both MULDIV_DIV_EN builds.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    muldiv_if bus ();

    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done (bounded); inject=1 pokes a start at k=10 and hi_we at k=12.
    task automatic wait_result(input string tag, input bit b2b, input bit inject, input logic [31:0] prev_hi);
        int   k = 0;
        int   busy_n = 0;
        exp_t e;
        while (!bus.done && k < 100) begin
            if (bus.busy) busy_n++;
            if (inject && k == 10) begin
                bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd9; bus.src_b = 32'd9;
            end else if (inject && k == 12) begin
                bus.start = 1'b0; bus.hi_we = 1'b1; bus.src_a = 32'd5;
            end else begin
                bus.start = 1'b0; bus.hi_we = 1'b0;
            end
            if (inject && k == 13) check_eq({tag, "_hi_we_ignored"}, bus.hi, prev_hi);
            tick();
            k++;
        end
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check_eq({tag, "_done"}, bus.done, 1'b1);
        check_eq({tag, "_latency"}, k, 33);
        check_eq({tag, "_busy_cycles"}, busy_n, 33);
        check_eq({tag, "_busy_at_done"}, bus.busy, 1'b0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({e.tag, "_hi"}, bus.hi, e.hi);
            check_eq({e.tag, "_lo"}, bus.lo, e.lo);
        end
        if (!b2b) begin
            tick();
            check_eq({tag, "_done_pulse"}, bus.done, 1'b0);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input bit b2b);
        exp_t e;
        e.tag = tag; e.hi = eh; e.lo = el;
        sb.push_back(e);
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
        tick();
        bus.start = 1'b0;
        wait_result(tag, b2b, 1'b0, 32'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = 32'd0; bus.src_b = 32'd0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("reset_hi", bus.hi, 32'd0);
        check_eq("reset_lo", bus.lo, 32'd0);
        check_eq("reset_busy", bus.busy, 1'b0);
        check_eq("reset_done", bus.done, 1'b0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

        // Running MULTU 6*7 with a stray start and MTHI while busy.
        sb.push_back('{tag: "multu_ignore", hi: 32'd0, lo: 32'd42});
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd6; bus.src_b = 32'd7;
        tick();
        bus.start = 1'b0;
        wait_result("multu_ignore", 1'b0, 1'b1, 32'hFFFF_FFFF);

        // Reset in the middle of a run.
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd6; bus.src_b = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        check_eq("pre_rst_busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_hi", bus.hi, 32'd0);
        check_eq("rst_mid_lo", bus.lo, 32'd0);
        check_eq("rst_mid_busy", bus.busy, 1'b0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check_eq("rst_no_done", seen, 1'b0);
        check_eq("rst_after_lo", bus.lo, 32'd0);

        // MTHI, then MTHI+MTLO together.
        bus.hi_we = 1'b1; bus.src_a = 32'd5;
        tick();
        bus.hi_we = 1'b0;
        check_eq("mthi_hi", bus.hi, 32'd5);
        check_eq("mthi_lo", bus.lo, 32'd0);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.src_a = 32'd9;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check_eq("mthilo_hi", bus.hi, 32'd9);
        check_eq("mthilo_lo", bus.lo, 32'd9);

        // start wins over hi_we/lo_we in the same cycle.
        sb.push_back('{tag: "start_prio", hi: 32'd0, lo: 32'd12});
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd3; bus.src_b = 32'd4;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        tick();
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check_eq("start_prio_hi_kept", bus.hi, 32'd9);
        check_eq("start_prio_lo_kept", bus.lo, 32'd9);
        wait_result("start_prio", 1'b0, 1'b0, 32'd0);

`ifdef MULDIV_DIV_EN
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        run_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_pos_neg", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("div_neg_zero", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
`else
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd10; bus.src_b = 32'd3;
        tick();
        bus.start = 1'b0;
        check_eq("divnop_busy", bus.busy, 1'b0);
        check_eq("divnop_done", bus.done, 1'b1);
        check_eq("divnop_hi", bus.hi, 32'd0);
        check_eq("divnop_lo", bus.lo, 32'd12);
        // Start accepted in the cycle done is high.
        run_op("multu_10_3", 2'b01, 32'd10, 32'd3, 32'd0, 32'd30, 1'b0);
`endif

        check_eq("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit holding the architectural HI/LO registers of the MIPS-lite datapath. It sits directly downstream of the register file: operands come straight from the two GPR read ports (rs, rt). HI/LO are exposed so the MFHI/MFLO path can return them to the GPR write port. Operation is a multi-cycle FSM with a start/busy/done handshake, so the control unit stalls while the unit works.

## Interface
Parameters:
- none

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; clock clk
- start  input  1  launch operation selected by op; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  32  rs operand (multiplicand / dividend / MTHI-MTLO data)
- src_b  input  32  rt operand (multiplier / divisor)
- hi_we  input  1  MTHI: HI <= src_a, IDLE only
- lo_we  input  1  MTLO: LO <= src_a, IDLE only
- busy  output  1  high while RUN or FIX
- done  output  1  one-cycle pulse when HI/LO take a new result
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Latch operand magnitudes: absolute values for MULT/DIV, raw values for MULTU/DIVU.
  - Latch result signs; clear the 6-bit iteration counter; go to RUN.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring, with a 33-bit partial remainder.
  - After 32 steps go to FIX.
- FIX:
  - Apply sign correction (two's-complement negate).
  - Write HI/LO, pulse done, return to IDLE.
- Multiply result: {HI,LO} = 64-bit product. Signed when op=MULT, unsigned when op=MULTU.
- Divide result: LO = quotient, HI = remainder.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Quotient truncates toward zero.
- Divide boundary cases:
  - Divide by zero (src_b=0), DIV or DIVU: full 32-step run, then LO=32'hFFFF_FFFF and HI=src_a as captured (raw).
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0 (wraps, no trap).
- start while busy: ignored; operands and op of the running operation unaffected.
- hi_we/lo_we:
  - Honoured only in IDLE when start=0.
  - Dropped when start=1 in the same cycle (start has priority).
  - Dropped while busy.
  - hi_we and lo_we together write both registers.
- HI/LO hold their value until FIX or an accepted hi_we/lo_we.
- Reset, including mid-operation: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0. No partial result is ever written.

## Timing
- Start accepted at edge E0.
- busy=1 from after E0 through the cycle ending at E33.
- RUN steps occur on edges E1..E32; FIX is sampled on E33.
- After E33: hi/lo hold the result, done=1 for exactly one cycle, busy=0.
- Latency is 33 cycles from the start edge to result visible.
- A new start can be accepted in the same cycle done is high (back-to-back throughput: 34 cycles).
- MTHI/MTLO latency: 1 cycle; new value visible after the write edge.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- MULDIV_DIV_EN defined:
  - Divider datapath compiled in; DIV/DIVU behave as above.
- MULDIV_DIV_EN undefined:
  - Divider logic removed.
  - start with op=DIV or DIVU leaves HI/LO unchanged and does not enter RUN.
  - busy stays 0; done pulses for one cycle after the start edge, so control never hangs.
  - MULT/MULTU and MTHI/MTLO are unaffected.

## Test plan
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> after 33 cycles HI=32'hFFFF_FFFE, LO=32'h0000_0001, done single pulse, busy high exactly 33 cycles.
- MULT a=-3, b=5 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF1.
- DIV a=-7, b=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- DIVU a=32'h1234_5678, b=0 -> LO=32'hFFFF_FFFF, HI=32'h1234_5678.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF -> LO=32'h8000_0000, HI=0.
- MULTU 6*7 running:
  - start (MULTU 9*9) at cycle 10 -> ignored; final LO=42.
  - hi_we with src_a=5 at cycle 12 -> ignored; final HI=0.
  - rst at cycle 20 of a second run -> hi=lo=0, busy=0, no done pulse.
  - Without MULTU 6*7 running, MTHI src_a=5 -> HI=5 on the next cycle.
- With MULDIV_DIV_EN undefined:
  - DIVU 10/3 -> busy stays 0, done pulses once, HI/LO unchanged.
  - MULTU 10*3 -> LO=30.
